uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLOCK_DIV, default 104, clocks per bit (12 MHz / 115200).
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 uart_rx  in  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-006 bus_valid  in  1  bus access this cycle.
REQ-007 bus_write  in  1  1 = write, 0 = read; qualified by bus_valid.
REQ-008 bus_addr  in  3  word offset (byte address bits [4:2]).
REQ-009 bus_wdata  in  32  write data.
REQ-010 bus_rdata  out  32  read data, registered, valid the cycle after the read request.
REQ-011 irq_rx  out  1  high while FIFO is non-empty.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer; receiver logic uses only the synchronized value.
REQ-013 Receiver states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: synchronized rx low -> START, clock counter = CLOCK_DIV/2.
REQ-015 Counter decrements each cycle; a sample occurs when it reaches 0, then reloads to CLOCK_DIV-1.
REQ-016 START sample: rx=1 -> IDLE (glitch, nothing recorded); rx=0 -> DATA, bit count 0.
REQ-017 DATA: each sample shifts rx into bit 7 of the shift register (LSB first); after the 8th sample -> STOP.
REQ-018 STOP sample rx=1: byte pushed if FIFO not full, else byte dropped and overflow flag set; -> IDLE.
REQ-019 STOP sample rx=0: byte discarded, frame_err flag set; -> WAIT_HIGH, which returns to IDLE when rx=1.
REQ-020 A pushed byte SHALL be visible in status and irq_rx the cycle after the stop-bit sample.
REQ-021 Read at offset 1 (DATA): bus_rdata = {24'b0, head byte}; pops the FIFO if non-empty; if empty returns 0 and does not pop.
REQ-022 Read at offset 4 (STATUS): bit0 non-empty, bit1 overflow, bit2 frame_err, bits[4+DEPTH_LOG2:4] count, other bits 0.
REQ-023 Reads at other offsets return 0 with no side effect.
REQ-024 Write at offset 4: wdata bit1=1 clears overflow, bit2=1 clears frame_err (write-1-to-clear); writes elsewhere are ignored.
REQ-025 Flag set and clear in the same cycle: set wins.
REQ-026 Push and pop in the same cycle: both performed, count unchanged; this holds when full (push accepted, no overflow).
REQ-027 Count SHALL be DEPTH_LOG2+1 bits wide; read/write pointers DEPTH_LOG2 bits and wrap modulo depth.
REQ-028 Receiver SHALL run independently of bus activity; no bus access stalls reception.

Reset
REQ-029 rst SHALL force: receiver state IDLE, FIFO empty (pointers and count 0), overflow=0, frame_err=0, bus_rdata=0, irq_rx=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL abandon the frame; no partial byte is pushed.
REQ-031 FIFO storage contents need not be reset.

Structure
REQ-032 Shared package uart_pkg SHALL hold register offsets (DATA=1, STATUS=4), status bit positions, the receiver state enum, and the default CLOCK_DIV.
REQ-033 The FIFO SHALL be the sub-module sync_fifo (parameter DEPTH_LOG2, width 8, push/pop/full/empty/count); deserializer and bus decode stay in uart_rx_fifo.

Verification
REQ-034 Send 0x55 at CLOCK_DIV=104 -> STATUS reads 0x011; DATA reads 0x55; STATUS then reads 0x000, irq_rx low.
REQ-035 Send 17 bytes 0x00..0x10 with no reads -> STATUS 0x103; 16 DATA reads return 0x00..0x0F in order; 17th read returns 0.
REQ-036 Send 0xA5 with stop bit 0 -> STATUS 0x004, FIFO empty; hold rx low 3 bit times -> no byte; write 0x4 to STATUS -> 0x000.
REQ-037 Pulse rx low for 26 cycles -> no byte, STATUS 0x000; receiver accepts a following 0x3C correctly.
REQ-038 FIFO full, DATA read in the same cycle as stop-bit push of 0x7E -> count stays 16, overflow 0, 0x7E returned last.
REQ-039 Assert rst during DATA bits of a frame -> after release STATUS 0x000, bus_rdata 0, next complete frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO: register map, status layout,
// receiver states and the default bit period.
package uart_pkg;
  localparam int DEFAULT_CLOCK_DIV = 104;

  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int STAT_NE   = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_FERR = 2;
  localparam int STAT_CNT  = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head and an occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        wdata,
  input  logic                pop,
  output logic [W-1:0]        rdata,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]     cnt_q;
  logic                    do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, with a small register interface
// (DATA pops, STATUS reports flags/count, write-1-to-clear flags).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_DIV  = DEFAULT_CLOCK_DIV,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq_rx
);
  localparam int CW = $clog2(CLOCK_DIV + 1);
  localparam logic [CW-1:0] HALF   = CW'(CLOCK_DIV / 2);
  localparam logic [CW-1:0] RELOAD = CW'(CLOCK_DIV - 1);

  logic [1:0]          sync_q;
  logic                rx_s;
  rx_state_e           state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          bitcnt_q;
  logic [7:0]          shift_q;
  logic                ovf_q, ovf_d, ferr_q, ferr_d;
  logic [31:0]         rdata_q, rdata_d, status;
  logic                tick, frame_end, stop_ok, rd, wr_stat, pop;
  logic                f_full, f_empty;
  logic [7:0]          f_head;
  logic [DEPTH_LOG2:0] f_count;
  logic                unused_wdata;

  assign rx_s      = sync_q[1];
  assign tick      = (cnt_q == '0);
  assign frame_end = (state_q == RX_STOP) && tick;
  assign stop_ok   = frame_end & rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      if (state_q != RX_IDLE && state_q != RX_WAIT_HIGH)
        cnt_q <= tick ? RELOAD : cnt_q - 1'b1;
      case (state_q)
        RX_IDLE: if (!rx_s) begin
          state_q <= RX_START;
          cnt_q   <= HALF;
        end
        RX_START: if (tick) begin
          state_q  <= rx_s ? RX_IDLE : RX_DATA;
          bitcnt_q <= '0;
        end
        RX_DATA: if (tick) begin
          shift_q  <= {rx_s, shift_q[7:1]};
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_q <= RX_STOP;
        end
        RX_STOP: if (tick) state_q <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
        RX_WAIT_HIGH: if (rx_s) state_q <= RX_IDLE;
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rd      = bus_valid & ~bus_write;
  assign wr_stat = bus_valid & bus_write & (bus_addr == REG_STATUS);
  assign pop     = rd & (bus_addr == REG_DATA) & ~f_empty;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stop_ok),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    status = '0;
    status[STAT_NE]   = ~f_empty;
    status[STAT_OVF]  = ovf_q;
    status[STAT_FERR] = ferr_q;
    status[STAT_CNT +: DEPTH_LOG2+1] = f_count;

    // A same-cycle pop frees the slot, so a full FIFO only overflows without one.
    ovf_d  = (stop_ok & f_full & ~pop) | (ovf_q & ~(wr_stat & bus_wdata[STAT_OVF]));
    ferr_d = (frame_end & ~rx_s) | (ferr_q & ~(wr_stat & bus_wdata[STAT_FERR]));

    rdata_d = rdata_q;
    if (rd) begin
      case (bus_addr)
        REG_DATA:   rdata_d = f_empty ? 32'd0 : {24'd0, f_head};
        REG_STATUS: rdata_d = status;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_rdata    = rdata_q;
  assign irq_rx       = ~f_empty;
  assign unused_wdata = ^{bus_wdata[31:3], bus_wdata[0]};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, register reads checked
// against hand-computed values.
module tb_uart_rx_fifo;
  localparam int CD = 104;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        irq_rx;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.CLOCK_DIV(CD), .DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .bus_valid (bus_valid),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq_rx    (irq_rx)
  );

  always #5 clk = ~clk;

  // Start bit is driven just after edge E0; the DUT samples the stop bit at E0+992.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int low_after);
    @(posedge clk); #1;
    uart_rx = 1'b0; repeat (CD) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i]; repeat (CD) @(posedge clk); #1;
    end
    uart_rx = stop_b; repeat (CD) @(posedge clk); #1;
    if (low_after > 0) begin
      uart_rx = 1'b0; repeat (low_after) @(posedge clk); #1;
    end
    uart_rx = 1'b1; repeat (12) @(posedge clk);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    bus_valid = 1'b0;
    v = bus_rdata;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_valid = 1'b0; bus_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want %h", bus_rdata, 32'd0); end
    checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_rx); end
    rst = 1'b0;
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h000); end
  endtask

  task automatic test_single();
    logic [31:0] v;
    send_frame(8'h55, 1'b1, 0);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h011) begin errors++; $display("FAIL single_status: got %h want %h", v, 32'h011); end
    checks++; if (irq_rx !== 1'b1) begin errors++; $display("FAIL single_irq: got %b want 1", irq_rx); end
    bus_rd(3'd1, v);
    checks++; if (v !== 32'h55) begin errors++; $display("FAIL single_data: got %h want %h", v, 32'h55); end
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL single_status_after: got %h want %h", v, 32'h000); end
    checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL single_irq_after: got %b want 0", irq_rx); end
    bus_rd(3'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL other_offset: got %h want 0", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 0);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h103) begin errors++; $display("FAIL ovf_status: got %h want %h", v, 32'h103); end
    for (int i = 0; i < 16; i++) begin
      bus_rd(3'd1, v);
      checks++; if (v !== 32'(i)) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, v, 32'(i)); end
    end
    bus_rd(3'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovf_empty_read: got %h want 0", v); end
    bus_wr(3'd4, 32'h2);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL ovf_clear: got %h want %h", v, 32'h000); end
  endtask

  task automatic test_frame_err();
    logic [31:0] v;
    send_frame(8'hA5, 1'b0, 3 * CD);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h004) begin errors++; $display("FAIL ferr_status: got %h want %h", v, 32'h004); end
    bus_wr(3'd4, 32'h4);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL ferr_clear: got %h want %h", v, 32'h000); end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    @(posedge clk); #1;
    uart_rx = 1'b0; repeat (26) @(posedge clk); #1;
    uart_rx = 1'b1; repeat (2 * CD) @(posedge clk);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL glitch_status: got %h want %h", v, 32'h000); end
    send_frame(8'h3C, 1'b1, 0);
    bus_rd(3'd1, v);
    checks++; if (v !== 32'h3C) begin errors++; $display("FAIL glitch_next: got %h want %h", v, 32'h3C); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, got;
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, 0);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h101) begin errors++; $display("FAIL full_status: got %h want %h", v, 32'h101); end
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (991) @(posedge clk); #1;
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 3'd1;
        @(posedge clk); #1;
        bus_valid = 1'b0;
        got = bus_rdata;
      end
    join
    checks++; if (got !== 32'h40) begin errors++; $display("FAIL simul_pop: got %h want %h", got, 32'h40); end
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h101) begin errors++; $display("FAIL simul_status: got %h want %h", v, 32'h101); end
    for (int i = 1; i < 16; i++) begin
      bus_rd(3'd1, v);
      checks++; if (v !== 32'h40 + 32'(i)) begin errors++; $display("FAIL simul_data%0d: got %h want %h", i, v, 32'h40 + 32'(i)); end
    end
    bus_rd(3'd1, v);
    checks++; if (v !== 32'h7E) begin errors++; $display("FAIL simul_last: got %h want %h", v, 32'h7E); end
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL simul_drained: got %h want %h", v, 32'h000); end
  endtask

  // 0xF0 keeps the line high after bit 3, so the receiver sees no false start once reset lifts.
  task automatic test_reset_midframe();
    logic [31:0] v;
    send_frame(8'h11, 1'b1, 0);
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h011) begin errors++; $display("FAIL pre_reset_status: got %h want %h", v, 32'h011); end
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (250) @(posedge clk); #1;
        rst = 1'b1;
        repeat (320) @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", bus_rdata); end
    checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq_rx); end
    bus_rd(3'd4, v);
    checks++; if (v !== 32'h000) begin errors++; $display("FAIL midrst_status: got %h want %h", v, 32'h000); end
    send_frame(8'hC3, 1'b1, 0);
    bus_rd(3'd1, v);
    checks++; if (v !== 32'hC3) begin errors++; $display("FAIL midrst_next: got %h want %h", v, 32'hC3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
